// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
package pc_pkg;

  localparam int PC_W_DEF = 8;

  typedef enum logic [2:0] {
    SEL_START,
    SEL_RET,
    SEL_CALL,
    SEL_BF,
    SEL_BB,
    SEL_INC
  } sel_e;

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO with an occupancy pointer that runs 0..DEPTH.
module ret_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [W-1:0]   mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  top_idx;

  assign wr_idx  = sp[AW-1:0];
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign data_o  = mem[top_idx];
  assign full_o  = (sp == SPW'(DEPTH));
  assign empty_o = (sp == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sp <= '0;
    end else if (clear_i) begin
      sp <= '0;
    end else if (push_i) begin
      sp <= sp + SPW'(1);
    end else if (pop_i) begin
      sp <= sp - SPW'(1);
    end
  end

  // Entries are only ever read below sp, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with priority next-PC select,
// return-address stack and sticky control-error flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                PC_W        = PC_W_DEF,
  parameter int                STACK_DEPTH = 4,
  parameter logic [PC_W-1:0]   RESET_ADDR  = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            en_i,
  input  logic            start_i,
  input  logic [PC_W-1:0] startadd_i,
  input  logic            branchf_i,
  input  logic            branchb_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            stack_full_o,
  output logic            stack_empty_o,
  output logic            err_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] inc;
  logic [PC_W-1:0] nxt_pc;
  logic [PC_W-1:0] top;
  logic            err_q;
  logic            err_set;
  logic            push;
  logic            pop;
  logic            clr;
  logic            full;
  logic            empty;
  sel_e            sel;

  assign inc = pc_q + PC_W'(1);

  // Faulted controls fall back to a plain increment.
  always_comb begin
    sel     = SEL_INC;
    err_set = 1'b0;
    if (start_i) begin
      sel = SEL_START;
    end else if (ret_i) begin
      if (empty) err_set = 1'b1;
      else       sel     = SEL_RET;
    end else if (call_i) begin
      if (full) err_set = 1'b1;
      else      sel     = SEL_CALL;
    end else if (branchf_i && branchb_i) begin
      err_set = 1'b1;
    end else if (branchf_i) begin
      sel = SEL_BF;
    end else if (branchb_i) begin
      sel = SEL_BB;
    end
  end

  always_comb begin
    nxt_pc = inc;
    unique case (sel)
      SEL_START: nxt_pc = startadd_i;
      SEL_RET:   nxt_pc = top;
      SEL_CALL:  nxt_pc = target_i;
      SEL_BF:    nxt_pc = inc + target_i;
      SEL_BB:    nxt_pc = inc - target_i;
      SEL_INC:   nxt_pc = inc;
      default:   nxt_pc = inc;
    endcase
  end

  assign push = en_i && (sel == SEL_CALL);
  assign pop  = en_i && (sel == SEL_RET);
  assign clr  = en_i && (sel == SEL_START);

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clr),
    .data_i  (inc),
    .data_o  (top),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q  <= RESET_ADDR;
      err_q <= 1'b0;
    end else if (en_i) begin
      pc_q  <= nxt_pc;
      err_q <= err_q | err_set;
    end
  end

  assign pc_o          = pc_q;
  assign err_o         = err_q;
  assign stack_full_o  = full;
  assign stack_empty_o = empty;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_pc_unit;

  localparam int PC_W = 8;
  localparam int D    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] sa = '0;
  logic            bf = 1'b0;
  logic            bb = 1'b0;
  logic            call = 1'b0;
  logic            ret = 1'b0;
  logic [PC_W-1:0] tgt = '0;
  logic [PC_W-1:0] pc;
  logic            full;
  logic            empty;
  logic            err;

  int n_run = 0;
  int n_fail = 0;

  logic [PC_W-1:0] m_pc = '0;
  logic            m_err = 1'b0;
  logic [PC_W-1:0] m_stk [$];

  pc_unit #(
    .PC_W        (PC_W),
    .STACK_DEPTH (D),
    .RESET_ADDR  (8'h00)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .en_i          (en),
    .start_i       (start),
    .startadd_i    (sa),
    .branchf_i     (bf),
    .branchb_i     (bb),
    .call_i        (call),
    .ret_i         (ret),
    .target_i      (tgt),
    .pc_o          (pc),
    .stack_full_o  (full),
    .stack_empty_o (empty),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_pc", int'(pc), int'(m_pc));
    chk("model_err", int'(err), int'(m_err));
    chk("model_empty", int'(empty), int'(m_stk.size() == 0));
    chk("model_full", int'(full), int'(m_stk.size() == D));
  end

  function automatic void model_step();
    logic [PC_W-1:0] nx;
    nx = m_pc + 8'd1;
    if (!en) return;
    if (start) begin
      m_pc = sa;
      m_stk.delete();
    end else if (ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = nx; m_err = 1'b1; end
    end else if (call) begin
      if (m_stk.size() < D) begin
        m_stk.push_back(nx);
        m_pc = tgt;
      end else begin
        m_pc = nx;
        m_err = 1'b1;
      end
    end else if (bf && bb) begin
      m_pc = nx;
      m_err = 1'b1;
    end else if (bf) m_pc = nx + tgt;
    else if (bb) m_pc = nx - tgt;
    else m_pc = nx;
  endfunction

  task automatic step(input logic e, input logic s, input logic [7:0] a,
                      input logic f, input logic b, input logic c,
                      input logic r, input logic [7:0] t);
    en = e; start = s; sa = a; bf = f; bb = b;
    call = c; ret = r; tgt = t;
    @(posedge clk);
    #1;
    model_step();
    en = 1'b0; start = 1'b0; bf = 1'b0; bb = 1'b0;
    call = 1'b0; ret = 1'b0;
  endtask

  task automatic nop();
    step(1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_pc = 8'h00;
    m_err = 1'b0;
    m_stk.delete();
    #1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    step(1, 1, 8'hBE, 0, 0, 0, 0, 8'h00);
    chk("pre_be", int'(pc), 8'hBE);
    step(1, 1, 8'h00, 0, 0, 0, 0, 8'h00);
    chk("start0", int'(pc), 8'h00);
    chk("start0_empty", int'(empty), 1);

    step(1, 0, 8'h00, 1, 0, 0, 0, 8'h29);
    chk("bf29", int'(pc), 8'h2A);
    step(1, 0, 8'h00, 0, 1, 0, 0, 8'h05);
    chk("bb05", int'(pc), 8'h26);
    nop();
    chk("inc", int'(pc), 8'h27);

    step(1, 1, 8'h00, 0, 0, 0, 0, 8'h00);
    step(1, 0, 8'h00, 1, 0, 0, 0, 8'hFE);
    chk("wrap_bf", int'(pc), 8'hFF);
    step(1, 0, 8'h00, 0, 1, 0, 0, 8'hFF);
    chk("wrap_bb_ff", int'(pc), 8'h01);
    step(1, 1, 8'hFE, 0, 0, 0, 0, 8'h00);
    step(1, 0, 8'h00, 0, 1, 0, 0, 8'hFF);
    chk("wrap_bb_fe", int'(pc), 8'h00);
    chk("wrap_err", int'(err), 0);

    step(1, 1, 8'h10, 0, 0, 0, 0, 8'h00);
    step(1, 0, 8'h00, 0, 0, 1, 0, 8'h80);
    chk("call", int'(pc), 8'h80);
    chk("call_empty", int'(empty), 0);
    nop();
    nop();
    chk("call_inc", int'(pc), 8'h82);
    step(1, 0, 8'h00, 0, 0, 0, 1, 8'h00);
    chk("ret", int'(pc), 8'h11);
    chk("ret_empty", int'(empty), 1);

    step(1, 1, 8'h20, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < D + 1; i++)
      step(1, 0, 8'h00, 0, 0, 1, 0, 8'(8'h40 + 8'(i) * 8'h10));
    chk("ovf_pc", int'(pc), 8'h71);
    chk("ovf_full", int'(full), 1);
    chk("ovf_err", int'(err), 1);
    step(1, 0, 8'h00, 0, 0, 0, 1, 8'h00);
    chk("pop_top", int'(pc), 8'h61);
    for (int i = 0; i < D - 1; i++)
      step(1, 0, 8'h00, 0, 0, 0, 1, 8'h00);
    chk("pop_last", int'(pc), 8'h21);
    step(1, 1, 8'h05, 0, 0, 0, 0, 8'h00);
    chk("start_keeps_err", int'(err), 1);

    do_reset();
    step(1, 0, 8'h00, 0, 0, 0, 1, 8'h00);
    chk("ret_empty_pc", int'(pc), 8'h01);
    chk("ret_empty_err", int'(err), 1);

    do_reset();
    step(1, 0, 8'h00, 1, 1, 0, 0, 8'h33);
    chk("bfbb_pc", int'(pc), 8'h01);
    chk("bfbb_err", int'(err), 1);

    do_reset();
    step(1, 0, 8'h00, 0, 0, 1, 0, 8'h50);
    step(1, 1, 8'h60, 0, 0, 1, 0, 8'h70);
    chk("start_over_call", int'(pc), 8'h60);
    chk("start_over_call_e", int'(empty), 1);
    step(1, 0, 8'h00, 1, 0, 1, 0, 8'h90);
    chk("call_over_bf", int'(pc), 8'h90);
    for (int i = 0; i < 3; i++)
      step(0, 0, 8'h00, 1, 0, 0, 0, 8'h10);
    chk("hold_pc", int'(pc), 8'h90);
    chk("hold_empty", int'(empty), 0);
    step(0, 1, 8'h44, 0, 0, 0, 1, 8'h00);
    chk("hold_start", int'(pc), 8'h90);
    step(1, 0, 8'h00, 1, 1, 0, 0, 8'h00);
    chk("pre_rst_err", int'(err), 1);
    nop();

    do_reset();
    nop();
    chk("post_rst", int'(pc), 8'h01);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
